// File: rtl/instr_exec_unit.sv
// instr_exec_unit: fetches 32-bit instructions from the host command FIFO and
// executes NOOP / WRITE_REG / READ_REG against an internal register file, the
// DAC and the ADC (through the shared SPI master), pushing read results into
// the readback FIFO and keeping a sticky first-error status.
//
// Optional build macro INSTR_EXEC_STATUS_EN: index 15 of the internal space
// becomes a read-only status word {err_flag, err_code, 12'h0, exec_count}.
module instr_exec_unit #(
  parameter int NUM_REGS    = 16,
  parameter int REG_WIDTH   = 16,
  parameter int SPI_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_ready,
  output logic        instr_ack,
  input  logic [31:0] instr_in,
  input  logic        readback_ready,
  output logic        readback_write,
  output logic [31:0] readback_data,
  output logic        dac_request_write,
  output logic [4:0]  dac_address,
  output logic [11:0] dac_data,
  output logic        adc_request_write,
  output logic        adc_request_read,
  output logic [15:0] adc_address,
  output logic [7:0]  adc_data,
  input  logic [7:0]  adc_data_readback,
  input  logic        spi_busy,
  output logic        err_flag,
  output logic [2:0]  err_code,
  output logic [2:0]  cu_state,
  output logic [4:0]  cu_instr
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    PROC_INSTR    = 3'd1,
    SPI_REQ       = 3'd2,
    WAIT_BUSY     = 3'd3,
    WAIT_COMPLETE = 3'd4,
    PUSH_DATA     = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOOP  = 5'h00;
  localparam logic [4:0] OP_WRITE = 5'h01;
  localparam logic [4:0] OP_READ  = 5'h02;

  localparam logic [1:0] SEL_ADC = 2'b00;
  localparam logic [1:0] SEL_DAC = 2'b01;
  localparam logic [1:0] SEL_INT = 2'b10;

  localparam logic [2:0] ERR_OPCODE  = 3'd1;
  localparam logic [2:0] ERR_SELECT  = 3'd2;
  localparam logic [2:0] ERR_INDEX   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // The array always spans the full 4-bit index space so the index needs no
  // truncation; entries at or above NUM_REGS are never written and stay zero.
  localparam int RF_DEPTH = 16;
  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  localparam int CNT_W = (SPI_TIMEOUT > 1) ? $clog2(SPI_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(SPI_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic                  settled_q, settled_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]  regs_q [RF_DEPTH];
  logic [REG_WIDTH-1:0]  regs_d [RF_DEPTH];
  logic [31:0]           readback_data_q, readback_data_d;
  logic                  dac_req_q, dac_req_d;
  logic [4:0]            dac_address_q, dac_address_d;
  logic [11:0]           dac_data_q, dac_data_d;
  logic                  adc_wr_q, adc_wr_d;
  logic                  adc_rd_q, adc_rd_d;
  logic [15:0]           adc_address_q, adc_address_d;
  logic [7:0]            adc_data_q, adc_data_d;
  logic                  err_flag_q, err_flag_d;
  logic [2:0]            err_code_q, err_code_d;

  logic [4:0]  opc;
  logic [1:0]  sel;
  logic [3:0]  idx;
  logic        idx_bad;
  logic        is_read;
  logic        in_wait;
  logic        timed_out;
  logic        accept;
  logic        status_hit;
  logic [31:0] status_word;

  logic        err_raise;
  logic [2:0]  err_new;
  logic        err_clear;
  logic        tmo_exit;

  assign opc       = instr_q[31:27];
  assign sel       = instr_q[26:25];
  assign idx       = instr_q[24:21];
  assign idx_bad   = ({1'b0, idx} >= NUM_REGS_W);
  assign is_read   = (opc == OP_READ);
  assign in_wait   = (state_q == SPI_REQ) || (state_q == WAIT_BUSY) ||
                     (state_q == WAIT_COMPLETE);
  assign timed_out = in_wait && (cnt_q == TMO_LAST);

  // An instruction is accepted only after IDLE has lasted a full cycle, which
  // gives the FIFO's registered empty flag time to reflect the previous pop
  // and enforces at least three cycles between acks.
  assign accept    = (state_q == IDLE) && settled_q && instr_ready;

`ifdef INSTR_EXEC_STATUS_EN
  logic [15:0] exec_cnt_q, exec_cnt_d;

  assign status_hit  = (idx == 4'hF);
  assign status_word = {err_flag_q, err_code_q, 12'h000, exec_cnt_q};

  // Executed-instruction counter, wraps naturally at 16 bits.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    if (accept) exec_cnt_d = exec_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) exec_cnt_q <= '0;
    else          exec_cnt_q <= exec_cnt_d;
  end
`else
  assign status_hit  = 1'b0;
  assign status_word = 32'h0000_0000;
`endif

  // Next-state and datapath decisions for the instruction sequencer.
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    regs_d          = regs_q;
    readback_data_d = readback_data_q;
    dac_req_d       = 1'b0;
    dac_address_d   = dac_address_q;
    dac_data_d      = dac_data_q;
    adc_wr_d        = 1'b0;
    adc_rd_d        = 1'b0;
    adc_address_d   = adc_address_q;
    adc_data_d      = adc_data_q;
    err_flag_d      = err_flag_q;
    err_code_d      = err_code_q;
    err_raise       = 1'b0;
    err_new         = 3'd0;
    err_clear       = 1'b0;
    tmo_exit        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = instr_in;
          state_d = PROC_INSTR;
        end
      end

      PROC_INSTR: begin
        state_d = IDLE;
        case (opc)
          OP_NOOP: err_clear = instr_q[0];
          OP_WRITE: begin
            case (sel)
              SEL_INT: begin
                if (status_hit || idx_bad) begin
                  err_raise = 1'b1;
                  err_new   = ERR_INDEX;
                end else begin
                  regs_d[idx] = instr_q[5 +: REG_WIDTH];
                end
              end
              SEL_DAC: begin
                dac_address_d = instr_q[24:20];
                dac_data_d    = instr_q[19:8];
                state_d       = SPI_REQ;
              end
              SEL_ADC: begin
                adc_address_d = instr_q[24:9];
                adc_data_d    = instr_q[8:1];
                state_d       = SPI_REQ;
              end
              default: begin
                err_raise = 1'b1;
                err_new   = ERR_SELECT;
              end
            endcase
          end
          OP_READ: begin
            case (sel)
              SEL_INT: begin
                state_d = PUSH_DATA;
                if (status_hit) begin
                  readback_data_d = status_word;
                end else if (idx_bad) begin
                  err_raise       = 1'b1;
                  err_new         = ERR_INDEX;
                  readback_data_d = ALL_ONES;
                end else begin
                  readback_data_d = {{(32-REG_WIDTH){1'b0}}, regs_q[idx]};
                end
              end
              SEL_ADC: begin
                adc_address_d = instr_q[24:9];
                state_d       = SPI_REQ;
              end
              default: begin
                err_raise       = 1'b1;
                err_new         = ERR_SELECT;
                readback_data_d = ALL_ONES;
                state_d         = PUSH_DATA;
              end
            endcase
          end
          default: begin
            err_raise = 1'b1;
            err_new   = ERR_OPCODE;
          end
        endcase
      end

      SPI_REQ: begin
        if (!spi_busy) begin
          if (sel == SEL_DAC)  dac_req_d = 1'b1;
          else if (is_read)    adc_rd_d  = 1'b1;
          else                 adc_wr_d  = 1'b1;
          state_d = WAIT_BUSY;
        end else if (timed_out) begin
          tmo_exit = 1'b1;
        end
      end

      WAIT_BUSY: begin
        if (spi_busy)       state_d  = WAIT_COMPLETE;
        else if (timed_out) tmo_exit = 1'b1;
      end

      WAIT_COMPLETE: begin
        if (!spi_busy) begin
          if (is_read) begin
            readback_data_d = {24'h000000, adc_data_readback};
            state_d         = PUSH_DATA;
          end else begin
            state_d = IDLE;
          end
        end else if (timed_out) begin
          tmo_exit = 1'b1;
        end
      end

      PUSH_DATA: begin
        if (readback_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A stalled SPI transaction is abandoned; reads still deliver a word so
    // the host never waits forever on the readback FIFO.
    if (tmo_exit) begin
      err_raise = 1'b1;
      err_new   = ERR_TIMEOUT;
      if (is_read) begin
        readback_data_d = ALL_ONES;
        state_d         = PUSH_DATA;
      end else begin
        state_d = IDLE;
      end
    end

    // Sticky status: only the first error after a clear is recorded.
    if (err_clear) begin
      err_flag_d = 1'b0;
      err_code_d = 3'd0;
    end else if (err_raise && !err_flag_q) begin
      err_flag_d = 1'b1;
      err_code_d = err_new;
    end
  end

  // Wait-state cycle counter, restarted on every state change.
  always_comb begin
    settled_d = (state_q == IDLE);
    if ((state_d != state_q) || !in_wait) cnt_d = '0;
    else                                  cnt_d = cnt_q + 1'b1;
  end

  // State, instruction latch, register file and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      instr_q         <= '0;
      settled_q       <= 1'b0;
      cnt_q           <= '0;
      for (int i = 0; i < RF_DEPTH; i++) regs_q[i] <= '0;
      readback_data_q <= '0;
      dac_req_q       <= 1'b0;
      dac_address_q   <= '0;
      dac_data_q      <= '0;
      adc_wr_q        <= 1'b0;
      adc_rd_q        <= 1'b0;
      adc_address_q   <= '0;
      adc_data_q      <= '0;
      err_flag_q      <= 1'b0;
      err_code_q      <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      settled_q       <= settled_d;
      cnt_q           <= cnt_d;
      regs_q          <= regs_d;
      readback_data_q <= readback_data_d;
      dac_req_q       <= dac_req_d;
      dac_address_q   <= dac_address_d;
      dac_data_q      <= dac_data_d;
      adc_wr_q        <= adc_wr_d;
      adc_rd_q        <= adc_rd_d;
      adc_address_q   <= adc_address_d;
      adc_data_q      <= adc_data_d;
      err_flag_q      <= err_flag_d;
      err_code_q      <= err_code_d;
    end
  end

  assign instr_ack         = accept;
  assign readback_write    = (state_q == PUSH_DATA) && readback_ready;
  assign readback_data     = readback_data_q;
  assign dac_request_write = dac_req_q;
  assign dac_address       = dac_address_q;
  assign dac_data          = dac_data_q;
  assign adc_request_write = adc_wr_q;
  assign adc_request_read  = adc_rd_q;
  assign adc_address       = adc_address_q;
  assign adc_data          = adc_data_q;
  assign err_flag          = err_flag_q;
  assign err_code          = err_code_q;
  assign cu_state          = state_q;
  assign cu_instr          = instr_q[31:27];

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed testbench for instr_exec_unit (NUM_REGS=8, SPI_TIMEOUT=16).
module tb_instr_exec_unit;

  localparam int NUM_REGS    = 8;
  localparam int REG_WIDTH   = 16;
  localparam int SPI_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_ready = 1'b0;
  logic        instr_ack;
  logic [31:0] instr_in = '0;
  logic        readback_ready = 1'b0;
  logic        readback_write;
  logic [31:0] readback_data;
  logic        dac_request_write;
  logic [4:0]  dac_address;
  logic [11:0] dac_data;
  logic        adc_request_write;
  logic        adc_request_read;
  logic [15:0] adc_address;
  logic [7:0]  adc_data;
  logic [7:0]  adc_data_readback = '0;
  logic        spi_busy = 1'b0;
  logic        err_flag;
  logic [2:0]  err_code;
  logic [2:0]  cu_state;
  logic [4:0]  cu_instr;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int ack_cnt = 0, push_cnt = 0, dac_cnt = 0, adcw_cnt = 0, adcr_cnt = 0;
  int last_ack = -1000;
  int min_gap = 1000;

  instr_exec_unit #(
    .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .SPI_TIMEOUT(SPI_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_ready(instr_ready), .instr_ack(instr_ack), .instr_in(instr_in),
    .readback_ready(readback_ready), .readback_write(readback_write),
    .readback_data(readback_data),
    .dac_request_write(dac_request_write), .dac_address(dac_address),
    .dac_data(dac_data),
    .adc_request_write(adc_request_write), .adc_request_read(adc_request_read),
    .adc_address(adc_address), .adc_data(adc_data),
    .adc_data_readback(adc_data_readback), .spi_busy(spi_busy),
    .err_flag(err_flag), .err_code(err_code),
    .cu_state(cu_state), .cu_instr(cu_instr)
  );

  always #10 clk = ~clk;

  // Strobe counters and ack spacing, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (instr_ack) begin
      ack_cnt++;
      if (cyc - last_ack < min_gap) min_gap = cyc - last_ack;
      last_ack = cyc;
    end
    if (readback_write)    push_cnt++;
    if (dac_request_write) dac_cnt++;
    if (adc_request_write) adcw_cnt++;
    if (adc_request_read)  adcr_cnt++;
  end

  function automatic logic [31:0] int_wr(input logic [3:0] i, input logic [15:0] d);
    return {5'h01, 2'b10, i, d, 5'b00000};
  endfunction
  function automatic logic [31:0] int_rd(input logic [3:0] i);
    return {5'h02, 2'b10, i, 21'h0};
  endfunction
  function automatic logic [31:0] dac_wr(input logic [4:0] a, input logic [11:0] d);
    return {5'h01, 2'b01, a, d, 8'h00};
  endfunction
  function automatic logic [31:0] adc_wr(input logic [15:0] a, input logic [7:0] d);
    return {5'h01, 2'b00, a, d, 1'b0};
  endfunction
  function automatic logic [31:0] adc_rd(input logic [15:0] a);
    return {5'h02, 2'b00, a, 9'h000};
  endfunction
  function automatic logic [31:0] noop(input logic clr);
    return {5'h00, 26'h0, clr};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word as the FIFO head until it is popped.
  task automatic send(input logic [31:0] w);
    bit seen = 0;
    instr_in    = w;
    instr_ready = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (instr_ack) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL send_ack: no instr_ack for %h (got none, required one within 60 cycles)", w);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
  endtask

  task automatic wait_push(output logic [31:0] d, output bit ok);
    ok = 0;
    d  = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (readback_write) begin
        d  = readback_data;
        ok = 1;
      end
    end
  endtask

  task automatic expect_push(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bit ok;
    wait_push(d, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no readback_write seen, required data %h", name, exp);
    end else if (d !== exp) begin
      errors++;
      $display("FAIL %s: readback_data %h, required %h", name, d, exp);
    end
  endtask

  task automatic expect_err(input string name, input logic f, input logic [2:0] c);
    checks++;
    if (err_flag !== f || err_code !== c) begin
      errors++;
      $display("FAIL %s: err_flag/code %b/%0d, required %b/%0d", name, err_flag, err_code, f, c);
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    instr_ready = 1'b1;
    instr_in    = int_wr(4'd1, 16'h1111);
    repeat (3) @(negedge clk);
    checks++;
    if (instr_ack !== 1'b0 || readback_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: ack/push %b/%b, required 0/0", instr_ack, readback_write);
    end
    checks++;
    if ({dac_request_write, adc_request_write, adc_request_read} !== 3'b000 ||
        dac_address !== 5'd0 || dac_data !== 12'd0 || adc_address !== 16'd0 ||
        adc_data !== 8'd0 || readback_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: spi/readback outputs not zero (dac %h/%h adc %h/%h rb %h)",
               dac_address, dac_data, adc_address, adc_data, readback_data);
    end
    expect_err("reset_err", 1'b0, 3'd0);
    checks++;
    if (cu_state !== 3'd0 || cu_instr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: cu_state/cu_instr %0d/%h, required 0/00", cu_state, cu_instr);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    reset_n     = 1'b1;
    tick(2);
  endtask

  task automatic test_int_regs();
    int p0;
    readback_ready = 1'b1;
    send(int_wr(4'd3, 16'hBEEF));
    send(int_rd(4'd3));
    p0 = push_cnt;
    expect_push("int_read_beef", 32'h0000_BEEF);
    tick(5);
    checks++;
    if (push_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL int_single_push: pushes %0d, required 1", push_cnt - p0);
    end
    checks++;
    if (cu_instr !== 5'h02) begin
      errors++;
      $display("FAIL cu_instr_read: %h, required 02", cu_instr);
    end
  endtask

  task automatic test_back_to_back();
    send(int_wr(4'd0, 16'h1234));
    send(int_wr(4'd1, 16'h5678));
    send(int_wr(4'd7, 16'hFFFF));
    send(int_rd(4'd0));
    expect_push("b2b_reg0", 32'h0000_1234);
    send(int_rd(4'd1));
    expect_push("b2b_reg1", 32'h0000_5678);
    send(int_rd(4'd7));
    expect_push("b2b_reg7", 32'h0000_FFFF);
  endtask

  task automatic test_dac_write();
    int d0, a0;
    bit seen = 0;
    d0 = dac_cnt;
    send(dac_wr(5'd7, 12'hABC));
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dac_request_write) seen = 1;
    end
    checks++;
    if (!seen || dac_address !== 5'd7 || dac_data !== 12'hABC) begin
      errors++;
      $display("FAIL dac_request: seen %b addr %0d data %h, required 1/7/abc", seen, dac_address, dac_data);
    end
    @(posedge clk);
    #1;
    spi_busy    = 1'b1;
    instr_in    = noop(1'b0);
    instr_ready = 1'b1;
    a0 = ack_cnt;
    tick(5);
    checks++;
    if (cu_state !== 3'd4) begin
      errors++;
      $display("FAIL dac_wait_state: cu_state %0d, required 4", cu_state);
    end
    tick(5);
    checks++;
    if (ack_cnt !== a0) begin
      errors++;
      $display("FAIL dac_no_ack_busy: acks %0d during busy, required 0", ack_cnt - a0);
    end
    spi_busy = 1'b0;
    send(noop(1'b0));
    tick(3);
    checks++;
    if (dac_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL dac_single_pulse: pulses %0d, required 1", dac_cnt - d0);
    end
    expect_err("dac_no_err", 1'b0, 3'd0);
  endtask

  task automatic test_adc_write();
    int w0;
    bit seen = 0;
    w0 = adcw_cnt;
    send(adc_wr(16'hA55A, 8'h3C));
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (adc_request_write) seen = 1;
    end
    @(posedge clk);
    #1;
    spi_busy = 1'b1;
    tick(2);
    spi_busy = 1'b0;
    tick(3);
    checks++;
    if (!seen || adcw_cnt - w0 !== 1 || adc_address !== 16'hA55A || adc_data !== 8'h3C) begin
      errors++;
      $display("FAIL adc_write: pulses %0d addr %h data %h, required 1/a55a/3c", adcw_cnt - w0, adc_address, adc_data);
    end
  endtask

  task automatic test_adc_read();
    int r0, p0;
    bit seen = 0;
    readback_ready    = 1'b0;
    adc_data_readback = 8'h5A;
    r0 = adcr_cnt;
    send(adc_rd(16'h0102));
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (adc_request_read) seen = 1;
    end
    checks++;
    if (!seen || adc_address !== 16'h0102) begin
      errors++;
      $display("FAIL adc_read_req: seen %b addr %h, required 1/0102", seen, adc_address);
    end
    @(posedge clk);
    #1;
    spi_busy = 1'b1;
    tick(3);
    spi_busy = 1'b0;
    p0 = push_cnt;
    tick(20);
    checks++;
    if (push_cnt !== p0 || cu_state !== 3'd5) begin
      errors++;
      $display("FAIL adc_backpressure: pushes %0d state %0d, required 0/5", push_cnt - p0, cu_state);
    end
    readback_ready = 1'b1;
    expect_push("adc_read_data", 32'h0000_005A);
    tick(4);
    checks++;
    if (push_cnt - p0 !== 1 || adcr_cnt - r0 !== 1 || readback_data !== 32'h0000_005A) begin
      errors++;
      $display("FAIL adc_read_once: pushes %0d reqs %0d data %h, required 1/1/0000005a",
               push_cnt - p0, adcr_cnt - r0, readback_data);
    end
  endtask

  task automatic test_timeout();
    spi_busy = 1'b0;
    send(adc_rd(16'h0010));
    expect_push("timeout_push", 32'hFFFF_FFFF);
    expect_err("timeout_err", 1'b1, 3'd4);
    send(noop(1'b1));
    tick(2);
    expect_err("timeout_clear", 1'b0, 3'd0);
  endtask

  task automatic test_errors();
    send({5'h1F, 27'h0});
    tick(2);
    expect_err("bad_opcode", 1'b1, 3'd1);
    send(int_rd(4'd12));
    expect_push("bad_index_read", 32'hFFFF_FFFF);
    expect_err("first_err_kept", 1'b1, 3'd1);
    send(noop(1'b1));
    send({5'h01, 2'b11, 25'h0});
    tick(2);
    expect_err("bad_select_write", 1'b1, 3'd2);
    send(noop(1'b1));
    send({5'h02, 2'b01, 25'h0});
    expect_push("dac_read_push", 32'hFFFF_FFFF);
    expect_err("dac_read_err", 1'b1, 3'd2);
    send(noop(1'b1));
    send(int_wr(4'd8, 16'h1111));
    tick(2);
    expect_err("index_boundary", 1'b1, 3'd3);
    send(int_rd(4'd0));
    expect_push("no_write_on_err", 32'h0000_1234);
    send(noop(1'b0));
    tick(2);
    expect_err("noop_no_clear", 1'b1, 3'd3);
    send(noop(1'b1));
    tick(2);
  endtask

  task automatic test_reset_mid();
    int r0;
    bit seen = 0;
    send({5'h1F, 27'h0});
    send(adc_rd(16'h0200));
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (adc_request_read) seen = 1;
    end
    @(posedge clk);
    #1;
    spi_busy = 1'b1;
    tick(2);
    checks++;
    if (cu_state !== 3'd4 || err_flag !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: state %0d err %b, required 4/1", cu_state, err_flag);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cu_state !== 3'd0 || adc_address !== 16'd0 || readback_data !== 32'd0 ||
        err_flag !== 1'b0 || err_code !== 3'd0 || cu_instr !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_async: state %0d adc %h rb %h err %b/%0d instr %h, required all 0",
               cu_state, adc_address, readback_data, err_flag, err_code, cu_instr);
    end
    tick(3);
    spi_busy = 1'b0;
    reset_n  = 1'b1;
    r0 = adcr_cnt;
    tick(20);
    checks++;
    if (adcr_cnt !== r0 || cu_state !== 3'd0) begin
      errors++;
      $display("FAIL mid_no_reissue: reqs %0d state %0d, required 0/0", adcr_cnt - r0, cu_state);
    end
    send(int_rd(4'd3));
    expect_push("mid_regs_cleared3", 32'h0000_0000);
    send(int_rd(4'd7));
    expect_push("mid_regs_cleared7", 32'h0000_0000);
  endtask

  initial begin
    test_reset();
    test_int_regs();
    test_back_to_back();
    test_dac_write();
    test_adc_write();
    test_adc_read();
    test_timeout();
    test_errors();
    test_reset_mid();
    checks++;
    if (min_gap < 3) begin
      errors++;
      $display("FAIL ack_spacing: minimum gap %0d cycles, required >= 3", min_gap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Parametrised next-generation instruction executor for the DAQ firmware.
- Fetches 32-bit instructions from the host command FIFO and executes NOOP/WRITE_REG/READ_REG against an internal register file, the DAC and the ADC.
- Completes SPI transactions with busy handshake and timeout, honours readback backpressure, and reports sticky error status.
- Sits between the host command/readback FIFOs and the shared SPI master.

Parameters:
- NUM_REGS, 16, number of internal registers (1..16; index field is 4 bits).
- REG_WIDTH, 16, internal register width (1..16); stored from instr[5 +: REG_WIDTH], read back zero-extended to 32.
- SPI_TIMEOUT, 1024, max clk cycles spent in each SPI wait state before error.

Ports:
- clk  in  1  50 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- instr_ready  in  1  command FIFO non-empty
- instr_ack  out  1  one-cycle pop of instr_in
- instr_in  in  32  instruction word
- readback_ready  in  1  readback FIFO can accept a word
- readback_write  out  1  one-cycle push strobe
- readback_data  out  32  readback word
- dac_request_write  out  1  one-cycle DAC write request
- dac_address  out  5  DAC channel
- dac_data  out  12  DAC code
- adc_request_write  out  1  one-cycle ADC register write request
- adc_request_read  out  1  one-cycle ADC register read request
- adc_address  out  16  ADC register address
- adc_data  out  8  ADC write data
- adc_data_readback  in  8  ADC read result, valid when spi_busy falls
- spi_busy  in  1  SPI master busy
- err_flag  out  1  sticky error
- err_code  out  3  code of first error since clear
- cu_state  out  3  debug: current state
- cu_instr  out  5  debug: latched opcode

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; register file cleared to 0; err_flag/err_code 0; latched instruction 0.
- Format: [31:27] opcode (NOOP=5'h00, WRITE_REG=5'h01, READ_REG=5'h02); [26:25] select (ADC=2'b00, DAC=2'b01, INT=2'b10). INT: [24:21] index, [20:5] data. DAC: [24:20] address, [19:8] data. ADC: [24:9] address, [8:1] data.
- States: IDLE=0, PROC_INSTR=1, SPI_REQ=2, WAIT_BUSY=3, WAIT_COMPLETE=4, PUSH_DATA=5.
- IDLE: when instr_ready=1, pulse instr_ack, latch instr_in, go to PROC_INSTR. Minimum spacing between acks is 3 cycles.
- PROC_INSTR:
  - NOOP: if instr[0]=1, clear err_flag/err_code. Go to IDLE.
  - WRITE_REG INT: write regs[idx], go to IDLE (total 2 cycles after ack).
  - READ_REG INT: load readback_data={zeros,regs[idx]}, go to PUSH_DATA.
  - ADC/DAC writes and READ_REG ADC: drive address/data outputs, go to SPI_REQ.
- SPI_REQ: wait until spi_busy=0, then pulse the matching request for 1 cycle and go to WAIT_BUSY. Address/data outputs hold until the next SPI instruction.
- WAIT_BUSY: on spi_busy=1, go to WAIT_COMPLETE.
- WAIT_COMPLETE: on spi_busy=0, either go to IDLE (writes) or latch {24'h0, adc_data_readback} and go to PUSH_DATA (ADC read).
- Timeout: a cycle counter resets on entry to each wait state. Reaching SPI_TIMEOUT raises error 4; a read then pushes 32'hFFFF_FFFF; otherwise go to IDLE.
- PUSH_DATA: pulse readback_write for exactly one cycle in which readback_ready=1, then go to IDLE. Wait indefinitely while readback_ready=0. readback_data holds its value until the next push.
- Errors: 1 = unknown opcode, 2 = bad select (2'b11, or READ_REG DAC), 3 = index >= NUM_REGS.
  - On error, the register file is not written.
  - A READ_REG that errors still pushes 32'hFFFF_FFFF.
  - err_code records only the first error while err_flag=1.
- Reset mid-operation: immediate IDLE; a pending SPI request is not reissued.

Optional Feature:
- Macro: INSTR_EXEC_STATUS_EN.
- Defined: READ_REG INT with index 4'hF returns the status word {err_flag, err_code, 12'h0, 16-bit executed-instruction count}. The count wraps at 16'hFFFF, increments on every ack, and clears on reset. With this macro defined, NUM_REGS is limited to <=15 and index 15 is read-only; a write to it gives error 3.
- Undefined: no counter logic; index 15 behaves as a normal register when NUM_REGS=16.

Test Plan:
- WRITE_REG INT idx 3 data 16'hBEEF, then READ_REG INT idx 3 -> one readback_write with data 32'h0000_BEEF.
- WRITE_REG DAC addr 5'd7 data 12'hABC, spi_busy high 10 cycles -> single dac_request_write pulse, dac_address=7, dac_data=12'hABC, next ack only after busy falls.
- READ_REG ADC addr 16'h0102, adc_data_readback=8'h5A when busy falls; hold readback_ready=0 for 20 cycles -> no push until ready, then data 32'h0000_005A.
- READ_REG ADC with spi_busy never rising, SPI_TIMEOUT=16 -> err_flag=1, err_code=4, push 32'hFFFF_FFFF; NOOP with bit0=1 -> err_flag=0.
- Opcode 5'h1F, then READ_REG INT idx 12 with NUM_REGS=8 -> err_code stays 1 (first error), second push returns 32'hFFFF_FFFF.
- reset_n asserted during WAIT_COMPLETE -> all outputs 0 immediately, state IDLE, regs 0.
